// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, its instruction memory and the decode stage.
// The slave side is the fetch stage itself; the master side drives control and memory data.
interface fetch_stage_if;
   logic        stall;
   logic        flush;
   logic        branch_taken;
   logic [31:0] branch_target;
   logic        jump;
   logic [31:0] jump_target;
   logic [31:0] instruction;
   logic [31:0] pc;
   logic [31:0] if_id_instr;
   logic [31:0] if_id_pc4;
   logic        if_id_valid;
   logic        halted;
   logic        misaligned;
   logic [15:0] fetch_count;

   modport master (
      output stall, flush, branch_taken, branch_target, jump, jump_target, instruction,
      input  pc, if_id_instr, if_id_pc4, if_id_valid, halted, misaligned, fetch_count
   );

   modport slave (
      input  stall, flush, branch_taken, branch_target, jump, jump_target, instruction,
      output pc, if_id_instr, if_id_pc4, if_id_valid, halted, misaligned, fetch_count
   );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fills the IF/ID register, handles
// stall/flush/branch/jump redirects and halts once the PC passes the last programmed word.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] LAST_PC  = 32'h0000_0024,
   parameter logic [31:0] NOP      = 32'h0000_0000
) (
   input logic           clk,
   input logic           rst_n,
   fetch_stage_if.slave  io_fs
);

   typedef enum logic [0:0] {StRun, StHalt} state_e;

   state_e      r_state;
   state_e      w_state_d;
   logic [31:0] r_pc;
   logic [31:0] w_pc_d;
   logic [31:0] r_instr;
   logic [31:0] w_instr_d;
   logic [31:0] r_pc4;
   logic [31:0] w_pc4_d;
   logic        r_valid;
   logic        w_valid_d;
   logic        r_mis;
   logic        w_mis_d;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_d;

   logic        w_redirect;
   logic [31:0] w_target;
   logic [31:0] w_pc_plus4;
   logic        w_bubble;

   assign w_redirect = io_fs.jump | io_fs.branch_taken;
   assign w_target   = io_fs.jump ? io_fs.jump_target : io_fs.branch_target;
   assign w_pc_plus4 = r_pc + 32'd4;

   // Priority: redirect > stall > halt check > normal fetch.
   always_comb begin
      w_state_d = r_state;
      w_pc_d    = r_pc;
      w_instr_d = r_instr;
      w_pc4_d   = r_pc4;
      w_valid_d = r_valid;
      w_mis_d   = r_mis;
      w_cnt_d   = r_cnt;
      w_bubble  = 1'b0;

      unique case (r_state)
         StRun: begin
            if (w_redirect) begin
               w_pc_d   = w_target & ~32'h3;
               w_bubble = 1'b1;
               if (w_target[1:0] != 2'b00) begin
                  w_mis_d = 1'b1;
               end
            end else if (io_fs.stall) begin
               w_bubble = io_fs.flush;
            end else if (r_pc > LAST_PC) begin
               w_bubble  = 1'b1;
               w_state_d = StHalt;
            end else begin
               w_pc_d = w_pc_plus4;
               if (io_fs.flush) begin
                  w_bubble = 1'b1;
               end else begin
                  w_instr_d = io_fs.instruction;
                  w_pc4_d   = w_pc_plus4;
                  w_valid_d = 1'b1;
                  if (r_cnt != 16'hFFFF) begin
                     w_cnt_d = r_cnt + 16'd1;
                  end
               end
            end
         end
         StHalt: begin
            w_bubble = 1'b1;
         end
      endcase

      // A bubble leaves if_id_pc4 untouched.
      if (w_bubble) begin
         w_instr_d = NOP;
         w_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StRun;
         r_pc    <= RESET_PC;
         r_instr <= NOP;
         r_pc4   <= 32'h0;
         r_valid <= 1'b0;
         r_mis   <= 1'b0;
         r_cnt   <= 16'h0;
      end else begin
         r_state <= w_state_d;
         r_pc    <= w_pc_d;
         r_instr <= w_instr_d;
         r_pc4   <= w_pc4_d;
         r_valid <= w_valid_d;
         r_mis   <= w_mis_d;
         r_cnt   <= w_cnt_d;
      end
   end

   assign io_fs.pc          = r_pc;
   assign io_fs.if_id_instr = r_instr;
   assign io_fs.if_id_pc4   = r_pc4;
   assign io_fs.if_id_valid = r_valid;
   assign io_fs.halted      = (r_state == StHalt);
   assign io_fs.misaligned  = r_mis;
   assign io_fs.fetch_count = r_cnt;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus random control traffic, with an
// architectural reference model feeding a scoreboard that a monitor drains each cycle.
module tb_fetch_stage;

   localparam logic [31:0] LastPc = 32'h0000_0024;

   logic clk;
   logic rst_n;
   fetch_stage_if bus ();

   fetch_stage #(
      .RESET_PC (32'h0),
      .LAST_PC  (LastPc),
      .NOP      (32'h0)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .io_fs (bus.slave)
   );

   logic [31:0] imem [64];
   assign bus.instruction = imem[bus.pc[7:2]];

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [31:0] pc4;
      logic        valid;
      logic        halt;
      logic        mis;
      logic [15:0] cnt;
   } exp_t;

   exp_t m;
   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic exp_t model_reset();
      exp_t r;
      r.pc = 32'h0; r.instr = 32'h0; r.pc4 = 32'h0; r.valid = 1'b0;
      r.halt = 1'b0; r.mis = 1'b0; r.cnt = 16'h0;
      return r;
   endfunction

   // One clock of architectural behaviour: what the machine looks like after the edge.
   function automatic exp_t step(exp_t s, logic j, logic [31:0] jt, logic b, logic [31:0] bt,
                                 logic st, logic f);
      exp_t        n = s;
      logic [31:0] tgt;
      logic [31:0] word = imem[s.pc[7:2]];
      logic        bub = 1'b1;
      if (s.halt) begin
         bub = 1'b1;
      end else if (j || b) begin
         tgt  = j ? jt : bt;
         n.pc = {tgt[31:2], 2'b00};
         if (tgt % 4 != 0) n.mis = 1'b1;
      end else if (st) begin
         bub = f;
      end else if (s.pc > LastPc) begin
         n.halt = 1'b1;
      end else begin
         n.pc = s.pc + 4;
         bub  = f;
         if (!f) begin
            n.instr = word;
            n.pc4   = s.pc + 4;
            n.valid = 1'b1;
            if (s.cnt < 16'hFFFF) n.cnt = s.cnt + 1;
         end
      end
      if (bub) begin
         n.instr = 32'h0;
         n.valid = 1'b0;
      end
      return n;
   endfunction

   task automatic cyc(input logic j, input logic [31:0] jt, input logic b, input logic [31:0] bt,
                      input logic st, input logic f);
      @(negedge clk);
      rst_n             = 1'b1;
      bus.jump          = j;
      bus.jump_target   = jt;
      bus.branch_taken  = b;
      bus.branch_target = bt;
      bus.stall         = st;
      bus.flush         = f;
      m = step(m, j, jt, b, bt, st, f);
      q.push_back(m);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic peek();
      @(posedge clk);
      #2;
   endtask

   task automatic check_reset_values();
      chk("rst_pc", bus.pc, 32'h0);
      chk("rst_instr", bus.if_id_instr, 32'h0);
      chk("rst_pc4", bus.if_id_pc4, 32'h0);
      chk("rst_valid", {31'h0, bus.if_id_valid}, 32'h0);
      chk("rst_halted", {31'h0, bus.halted}, 32'h0);
      chk("rst_mis", {31'h0, bus.misaligned}, 32'h0);
      chk("rst_cnt", {16'h0, bus.fetch_count}, 32'h0);
   endtask

   // Asynchronous reset dropped between edges; release happens in the next cyc().
   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_values();
      m = model_reset();
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("pc", bus.pc, e.pc);
            chk("if_id_instr", bus.if_id_instr, e.instr);
            chk("if_id_pc4", bus.if_id_pc4, e.pc4);
            chk("if_id_valid", {31'h0, bus.if_id_valid}, {31'h0, e.valid});
            chk("halted", {31'h0, bus.halted}, {31'h0, e.halt});
            chk("misaligned", {31'h0, bus.misaligned}, {31'h0, e.mis});
            chk("fetch_count", {16'h0, bus.fetch_count}, {16'h0, e.cnt});
         end
      end
   end

   initial begin : stimulus
      logic        j, b, st, f;
      logic [31:0] jt, bt;
      for (int i = 0; i < 64; i++) imem[i] = $urandom;
      rst_n             = 1'b0;
      bus.jump          = 1'b0;
      bus.jump_target   = 32'h0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 32'h0;
      bus.stall         = 1'b0;
      bus.flush         = 1'b0;
      m = model_reset();
      #3;
      check_reset_values();

      // Free run to halt.
      idle(1);
      peek();
      chk("first_instr", bus.if_id_instr, imem[0]);
      chk("first_pc4", bus.if_id_pc4, 32'h4);
      idle(15);
      peek();
      chk("free_halted", {31'h0, bus.halted}, 32'h1);
      chk("free_cnt", {16'h0, bus.fetch_count}, 32'd10);
      chk("free_pc", bus.pc, 32'h28);

      // Stall at pc=0x8.
      do_reset();
      idle(2);
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      cyc(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0);
      peek();
      chk("stall_pc", bus.pc, 32'h8);
      chk("stall_instr", bus.if_id_instr, imem[1]);
      chk("stall_pc4", bus.if_id_pc4, 32'h8);
      chk("stall_cnt", {16'h0, bus.fetch_count}, 32'd2);
      idle(1);
      peek();
      chk("stall_release_pc", bus.pc, 32'hC);

      // Branch from pc=0x8 to 0x10.
      do_reset();
      idle(2);
      cyc(1'b0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b0);
      peek();
      chk("br_pc", bus.pc, 32'h10);
      chk("br_bubble", {31'h0, bus.if_id_valid}, 32'h0);
      idle(1);
      peek();
      chk("br_instr", bus.if_id_instr, imem[4]);
      chk("br_pc4", bus.if_id_pc4, 32'h14);

      // Jump beats branch and stall; then a misaligned jump.
      do_reset();
      idle(2);
      cyc(1'b1, 32'h4, 1'b1, 32'h18, 1'b1, 1'b0);
      peek();
      chk("jmp_pc", bus.pc, 32'h4);
      chk("jmp_valid", {31'h0, bus.if_id_valid}, 32'h0);
      chk("jmp_mis", {31'h0, bus.misaligned}, 32'h0);
      cyc(1'b1, 32'h26, 1'b0, 32'h0, 1'b0, 1'b0);
      peek();
      chk("mis_pc", bus.pc, 32'h24);
      chk("mis_flag", {31'h0, bus.misaligned}, 32'h1);
      idle(25);
      peek();
      chk("mis_sticky", {31'h0, bus.misaligned}, 32'h1);
      chk("mis_halted", {31'h0, bus.halted}, 32'h1);

      // Async reset mid-run at pc=0x14, then a full run again.
      do_reset();
      idle(5);
      peek();
      chk("pre_rst_pc", bus.pc, 32'h14);
      chk("pre_rst_cnt", {16'h0, bus.fetch_count}, 32'd5);
      do_reset();
      idle(16);
      peek();
      chk("rerun_halted", {31'h0, bus.halted}, 32'h1);
      chk("rerun_cnt", {16'h0, bus.fetch_count}, 32'd10);

      // Random traffic.
      do_reset();
      for (int i = 0; i < 600; i++) begin
         if ((m.halt && $urandom_range(0, 3) == 0) || $urandom_range(0, 99) == 0) begin
            do_reset();
         end
         j  = ($urandom_range(0, 15) == 0);
         b  = ($urandom_range(0, 9) == 0);
         st = ($urandom_range(0, 5) == 0);
         f  = ($urandom_range(0, 7) == 0);
         jt = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         bt = {26'h0, 4'($urandom_range(0, 15)), 2'b00};
         if ($urandom_range(0, 7) == 0) jt[1:0] = 2'($urandom);
         if ($urandom_range(0, 7) == 0) bt[1:0] = 2'($urandom);
         cyc(j, jt, b, bt, st, f);
      end

      peek();
      #2;
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
